seq_multiplier_8bit: RTL and testbench



---
 rtl/seq_mult_pkg.sv | 27 ++
 rtl/seq_multiplier_8bit_if.sv | 24 ++
 rtl/ripple_carry_adder_8bit.sv | 23 ++
 rtl/seq_multiplier_8bit.sv | 134 +++++++++++++
 tb/tb_seq_multiplier_8bit.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pkg.sv
// Shared encodings, widths and payload types for the sequential 8x8 multiplier.
package seq_mult_pkg;

    localparam int unsigned WIDTH      = 8;
    localparam int unsigned PROD_W     = 2 * WIDTH;
    localparam int unsigned ITER_COUNT = 8;
    localparam int unsigned CNT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } operands_t;

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'({(WIDTH-1){1'b1}});

    // Selects the multiplier bits still to be consumed after iteration cnt.
    function automatic logic [WIDTH-1:0] unprocessed_mask(input logic [CNT_W-1:0] cnt);
        return LOW_MASK >> cnt;
    endfunction

endpackage

// File: rtl/seq_multiplier_8bit_if.sv
// Operand/product valid-ready bus between the operand source, the multiplier and its consumer.
interface seq_multiplier_8bit_if;
    import seq_mult_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] product;
    logic              busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );

endinterface

// File: rtl/ripple_carry_adder_8bit.sv
// 8-bit ripple-carry adder used as the per-iteration adder of the multiplier.
module ripple_carry_adder_8bit
    import seq_mult_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]     = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_multiplier_8bit.sv
// Unsigned 8x8 shift-and-add multiplier, one ripple-carry add per RUN cycle.
// Optional early termination on exhausted multiplier bits: SEQ_MULT_EARLY_TERM_EN.
module seq_multiplier_8bit
    import seq_mult_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    seq_multiplier_8bit_if.slave bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER_COUNT - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;

    operands_t         ops;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  add_s;
    logic              add_c;
    logic [WIDTH-1:0]  acc_upd;
    logic [WIDTH-1:0]  q_upd;
    logic [PROD_W-1:0] prod_upd;
    logic              done_now;

    assign ops = '{a: bus.a, b: bus.b};

    // Partial product plus multiplicand-or-zero, selected by the current multiplier LSB.
    assign add_b = q_q[0] ? mcand_q : '0;

    ripple_carry_adder_8bit u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_s),
        .cout (add_c)
    );

    // Carry enters acc MSB and sum LSB enters q MSB, so no bit is lost on the shift.
    assign acc_upd = {add_c, add_s[WIDTH-1:1]};
    assign q_upd   = {add_s[0], q_q[WIDTH-1:1]};

`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [CNT_W-1:0] shamt;

    // Stop once no set multiplier bits remain; realign the product for the skipped shifts.
    assign shamt    = LAST_CNT - cnt_q;
    assign done_now = (cnt_q == LAST_CNT) || ((q_upd & unprocessed_mask(cnt_q)) == '0);
    assign prod_upd = {acc_upd, q_upd} >> shamt;
`else
    assign done_now = (cnt_q == LAST_CNT);
    assign prod_upd = {acc_upd, q_upd};
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mcand_q     <= '0;
            q_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            q_q         <= q_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath update and registered-output decode.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        q_d       = q_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mcand_d = ops.a;
                    q_d     = ops.b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_upd;
                q_d   = q_upd;
                cnt_d = CNT_W'(cnt_q + 1'b1);
                if (done_now) begin
                    product_d = prod_upd;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d == ST_RUN);
        out_valid_d = (state_d == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.product   = product_q;

endmodule

// File: tb/tb_seq_multiplier_8bit.sv
// Bench for seq_multiplier_8bit: directed literal cases plus randomized traffic
// against a transaction-level model (product = a*b, fixed or bit-length latency).
module tb_seq_multiplier_8bit;
    import seq_mult_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_multiplier_8bit_if bif ();

    seq_multiplier_8bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 = waiting for operands, 1 = computing, 2 = holding a result.
    int          m_phase = 0;
    int          m_left  = 0;
    logic [15:0] m_pend  = '0;
    logic [15:0] m_prod  = '0;
    bit          m_known = 1'b0;

    function automatic int run_cycles(input logic [7:0] bv);
`ifdef SEQ_MULT_EARLY_TERM_EN
        for (int i = 7; i >= 0; i--) begin
            if (bv[i]) return i + 1;
        end
        return 1;
`else
        return 8;
`endif
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_prod  = '0;
                m_known = 1'b1;
            end else if (m_known) begin
                case (m_phase)
                    0: if (bif.in_valid) begin
                        m_phase = 1;
                        m_left  = run_cycles(bif.b);
                        m_pend  = 16'(bif.a) * 16'(bif.b);
                    end
                    1: begin
                        m_left = m_left - 1;
                        if (m_left == 0) begin
                            m_phase = 2;
                            m_prod  = m_pend;
                        end
                    end
                    default: if (bif.out_ready) m_phase = 0;
                endcase
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                vectors++;
                if (bif.in_ready !== (m_phase == 0) || bif.busy !== (m_phase == 1) ||
                    bif.out_valid !== (m_phase == 2) || bif.product !== m_prod) begin
                    miscompares++;
                    $display("FAIL cycle t=%0t: got rdy=%b busy=%b vld=%b prod=%h, want rdy=%b busy=%b vld=%b prod=%h",
                             $time, bif.in_ready, bif.busy, bif.out_valid, bif.product,
                             (m_phase == 0), (m_phase == 1), (m_phase == 2), m_prod);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int w = 0;
        while (bif.in_ready !== 1'b1 && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_timeout", 32'(bif.in_ready), 32'd1);
    endtask

    // One operation; exp_lat < 0 leaves latency to the per-cycle model.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input int hold,
                          input logic [15:0] exp_p, input int exp_lat, input bit pulse);
        int cyc = 0;
        bit seen = 1'b0;
        wait_ready();
        bif.in_valid = 1'b1;
        bif.a        = ta;
        bif.b        = tb_v;
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.a        = 8'($urandom);
        bif.b        = 8'($urandom);
        while (!seen && cyc < 20) begin
            if (pulse && cyc == 2) begin
                bif.in_valid = 1'b1;
                bif.a        = 8'h12;
                bif.b        = 8'h34;
            end else begin
                bif.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
            seen = (bif.out_valid === 1'b1);
        end
        bif.in_valid = 1'b0;
        check("out_valid_timeout", 32'(seen), 32'd1);
        check("product", 32'(bif.product), 32'(exp_p));
        if (exp_lat > 0) check("latency", 32'(cyc), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bif.out_valid), 32'd1);
            check("hold_product", 32'(bif.product), 32'(exp_p));
            check("hold_in_ready", 32'(bif.in_ready), 32'd0);
        end
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
        check("release_in_ready", 32'(bif.in_ready), 32'd1);
        check("release_valid", 32'(bif.out_valid), 32'd0);
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.a         = '0;
        bif.b         = '0;
        bif.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bif.in_ready), 32'd1);
        check("rst_out_valid", 32'(bif.out_valid), 32'd0);
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_product", 32'(bif.product), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(8'hFF, 8'hFF, 0, 16'hFE01, 8, 1'b0);
        run_op(8'h0D, 8'h0B, 0, 16'h008F, -1, 1'b0);
        run_op(8'h00, 8'hA5, 0, 16'h0000, -1, 1'b0);
        run_op(8'hFF, 8'hFF, 5, 16'hFE01, 8, 1'b0);
        run_op(8'h0D, 8'h0B, 0, 16'h008F, -1, 1'b1);

        // Reset lands on the fourth RUN edge of a 0xFF x 0xFF operation.
        wait_ready();
        bif.in_valid = 1'b1;
        bif.a        = 8'hFF;
        bif.b        = 8'hFF;
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(bif.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bif.out_valid), 32'd0);
        check("midrst_product", 32'(bif.product), 32'd0);
        run_op(8'h03, 8'h05, 0, 16'h000F, -1, 1'b0);

`ifdef SEQ_MULT_EARLY_TERM_EN
        run_op(8'h5A, 8'h00, 0, 16'h0000, 1, 1'b0);
        run_op(8'hFF, 8'h01, 0, 16'h00FF, 1, 1'b0);
        run_op(8'h10, 8'h05, 0, 16'h0050, 3, 1'b0);
`endif

        // Random traffic with occasional resets; checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 199) != 0);
            bif.in_valid  = ($urandom_range(0, 3) == 0);
            bif.a         = 8'($urandom);
            bif.b         = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            bif.out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
        end
        rst_n         = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_in_ready", 32'(bif.in_ready), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
